// File: rtl/mips_run_monitor.sv
// Run controller / execution monitor for the MIPS single-cycle core: start, count, terminate, PC history.
// Optional self-loop detection is compiled in when MIPS_RUN_MON_STALL_EN is defined.
module mips_run_monitor #(
  parameter int                 CNT_W       = 32,
  parameter int                 ADDR_W      = 32,
  parameter int                 MAX_CYCLES  = 18,
  parameter logic [ADDR_W-1:0]  HALT_ADDR   = 32'h0000_00FC,
  parameter int                 STALL_LIMIT = 4,
  parameter int                 HIST_DEPTH  = 8,
  localparam int                IDX_W       = $clog2(HIST_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              instr_valid,
  input  logic [ADDR_W-1:0] pc,
  input  logic [IDX_W-1:0]  hist_idx,
  output logic              running,
  output logic              done,
  output logic [1:0]        done_cause,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [ADDR_W-1:0] hist_pc,
  output logic              hist_hit
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d, ins_q, ins_d;
  logic [1:0]          cause_q, cause_d;
  logic [IDX_W-1:0]    wptr_q, wptr_d, rd_ptr;
  logic [IDX_W:0]      fill_q, fill_d;
  logic [ADDR_W-1:0]   hist_mem [HIST_DEPTH];
  logic                wr_en, halt_hit, bud_hit, loop_hit, launch;

  assign launch   = (state_q != S_RUN) && start;
  assign wr_en    = (state_q == S_RUN) && instr_valid;
  assign halt_hit = instr_valid && (pc == HALT_ADDR);
  assign bud_hit  = (cyc_q == CNT_W'(MAX_CYCLES - 1));

`ifdef MIPS_RUN_MON_STALL_EN
  localparam int REP_W = $clog2(STALL_LIMIT + 1);
  logic [ADDR_W-1:0] prev_q, prev_d;
  logic              have_q, have_d;
  logic [REP_W-1:0]  rep_q, rep_d;

  // A run of STALL_LIMIT+1 identical valid PCs means repeat count reaches STALL_LIMIT.
  assign loop_hit = instr_valid && have_q && (pc == prev_q) && (rep_q == REP_W'(STALL_LIMIT - 1));

  always_comb begin
    prev_d = prev_q;
    have_d = have_q;
    rep_d  = rep_q;
    if (launch) begin
      have_d = 1'b0;
      rep_d  = '0;
    end else if (wr_en) begin
      prev_d = pc;
      have_d = 1'b1;
      if (have_q && pc == prev_q) begin
        if (rep_q != REP_W'(STALL_LIMIT)) rep_d = rep_q + 1'b1;
      end else begin
        rep_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      have_q <= 1'b0;
      rep_q  <= '0;
    end else begin
      prev_q <= prev_d;
      have_q <= have_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign loop_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    cause_d = cause_q;
    wptr_d  = wptr_q;
    fill_d  = fill_q;
    unique case (state_q)
      S_RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (instr_valid) begin
          ins_d  = ins_q + 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (fill_q != (IDX_W+1)'(HIST_DEPTH)) fill_d = fill_q + 1'b1;
        end
        if (halt_hit)      cause_d = 2'b10;
        else if (loop_hit) cause_d = 2'b11;
        else if (bud_hit)  cause_d = 2'b01;
        if (halt_hit || loop_hit || bud_hit) state_d = S_DONE;
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          cyc_d   = '0;
          ins_d   = '0;
          cause_d = 2'b00;
          wptr_d  = '0;
          fill_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      ins_q   <= '0;
      cause_q <= 2'b00;
      wptr_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      cause_q <= cause_d;
      wptr_q  <= wptr_d;
      fill_q  <= fill_d;
    end
  end

  // Storage is unreset; fill_q gates every read so stale entries never escape.
  always_ff @(posedge clk) begin
    if (wr_en) hist_mem[wptr_q] <= pc;
  end

  assign rd_ptr     = wptr_q - IDX_W'(1) - hist_idx;
  assign hist_hit   = ({1'b0, hist_idx} < fill_q);
  assign hist_pc    = hist_hit ? hist_mem[rd_ptr] : '0;
  assign running    = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign done_cause = cause_q;
  assign cycle_cnt  = cyc_q;
  assign instr_cnt  = ins_q;
endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: expected run results go to a scoreboard checked on done.
module tb_mips_run_monitor;
  logic        clk, rst_n, start, instr_valid;
  logic [31:0] pc;
  logic [2:0]  hist_idx;
  logic        running, done, hist_hit;
  logic [1:0]  done_cause;
  logic [31:0] cycle_cnt, instr_cnt, hist_pc;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  mips_run_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_valid(instr_valid), .pc(pc),
    .hist_idx(hist_idx), .running(running), .done(done), .done_cause(done_cause),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .hist_pc(hist_pc), .hist_hit(hist_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] c, input int cy, input int in);
    exp_t e;
    e.cause = c;
    e.cyc   = 32'(cy);
    e.ins   = 32'(in);
    return e;
  endfunction

  // Monitor: one scoreboard entry per rising done.
  logic done_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || !done) begin
      done_seen = 1'b0;
    end else if (!done_seen) begin
      exp_t e;
      done_seen = 1'b1;
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("run_cause", 64'(done_cause), 64'(e.cause));
        chk("run_cycles", 64'(cycle_cnt), 64'(e.cyc));
        chk("run_instrs", 64'(instr_cnt), 64'(e.ins));
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    instr_valid = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic [31:0] p);
    @(negedge clk);
    start = 1'b0;
    instr_valid = v;
    pc = p;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      start = 1'b0;
      instr_valid = 1'b0;
      n++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
    @(negedge clk);
  endtask

  task automatic chk_hist(input string nm, input int idx, input logic hit, input logic [31:0] p);
    hist_idx = 3'(idx);
    #1;
    chk({nm, "_hit"}, 64'(hist_hit), 64'(hit));
    chk({nm, "_pc"}, 64'(hist_pc), 64'(p));
  endtask

  task automatic chk_reset_outs();
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cause", 64'(done_cause), 64'd0);
    chk("rst_cycles", 64'(cycle_cnt), 64'd0);
    chk("rst_instrs", 64'(instr_cnt), 64'd0);
    chk("rst_hist_hit", 64'(hist_hit), 64'd0);
    chk("rst_hist_pc", 64'(hist_pc), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0; pc = '0; hist_idx = '0;
    #1;
    chk_reset_outs();
    #21 rst_n = 1'b1;

    // Reset mid-run at cycle 5, then restart.
    do_start();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(i * 4));
    @(negedge clk);
    chk("mid_cycles", 64'(cycle_cnt), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs();
    #2 rst_n = 1'b1;
    sb.push_back(mk(2'b01, 18, 0));
    do_start();
    cyc(1'b0, 32'h0);
    @(negedge clk);
    chk("restart_cycles", 64'(cycle_cnt), 64'd1);
    chk("restart_running", 64'(running), 64'd1);
    wait_done();

    // Budget run, pc = 0,4,8,...
    sb.push_back(mk(2'b01, 18, 18));
    do_start();
    for (int i = 0; i < 18; i++) cyc(1'b1, 32'(i * 4));
    wait_done();

    // Halt address on the 10th retirement.
    sb.push_back(mk(2'b10, 10, 10));
    do_start();
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'hD8 + 32'(i * 4));
    wait_done();
    chk_hist("halt_h0", 0, 1'b1, 32'hFC);
    chk_hist("halt_h1", 1, 1'b1, 32'hF8);

    // PC 0x40 held: self-loop when enabled, otherwise budget.
`ifdef MIPS_RUN_MON_STALL_EN
    sb.push_back(mk(2'b11, 5, 5));
`else
    sb.push_back(mk(2'b01, 18, 18));
`endif
    do_start();
    for (int i = 0; i < 18; i++) cyc(1'b1, 32'h40);
    wait_done();

    // History wrap: 12 retirements of 4n.
    sb.push_back(mk(2'b01, 18, 12));
    do_start();
    for (int i = 0; i < 12; i++) cyc(1'b1, 32'(i * 4));
    wait_done();
    for (int i = 0; i < 8; i++) chk_hist("wrap", i, 1'b1, 32'(44 - 4 * i));

    // Fresh start, 3 retirements: partial fill.
    sb.push_back(mk(2'b01, 18, 3));
    do_start();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'd100 + 32'(i * 4));
    wait_done();
    chk_hist("part_h0", 0, 1'b1, 32'd108);
    chk_hist("part_h2", 2, 1'b1, 32'd100);
    chk_hist("part_h3", 3, 1'b0, 32'd0);

    // Halt and budget on the same edge: halt wins.
    sb.push_back(mk(2'b10, 18, 1));
    do_start();
    for (int i = 0; i < 17; i++) cyc(1'b0, 32'h0);
    cyc(1'b1, 32'hFC);
    wait_done();

    // Start in DONE restarts with everything cleared.
    sb.push_back(mk(2'b01, 18, 0));
    do_start();
    cyc(1'b0, 32'h0);
    chk("redo_running", 64'(running), 64'd1);
    chk("redo_done", 64'(done), 64'd0);
    chk("redo_cause", 64'(done_cause), 64'd0);
    chk("redo_cycles", 64'(cycle_cnt), 64'd0);
    chk("redo_instrs", 64'(instr_cnt), 64'd0);
    chk_hist("redo_h0", 0, 1'b0, 32'd0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
